icache_refill_ctrl: RTL and testbench
=====================================

// Module: icache_refill_ctrl
// PURPOSE
//  Miss-side partner of the icache victim selector. On a miss it latches the
//  victim way supplied by the replacement logic, issues one AXI-style read
//  burst for the missing line, and collects the beats in a line buffer. It
//  forwards the critical word, then writes tag and line into the victim way.
//  It sits between the icache lookup stage, the replacement unit and the bus.
// PARAMETERS
//  WAY_NUM     4   ways per set; wr_way/replace_line width = $clog2(WAY_NUM)
//  LINE_WORDS  8   32-bit words per line; burst length = LINE_WORDS beats
//  INDEX_W     7   set-index bits
//  ADDR_W      32  address width; OFFSET_W=$clog2(LINE_WORDS)+2, TAG_W=ADDR_W-INDEX_W-OFFSET_W
// PORTS
//  clk           in   1            clock
//  rst           in   1            reset
//  miss_valid    in   1            lookup reports miss for miss_addr
//  miss_addr     in   ADDR_W       byte address of missing fetch
//  replace_line  in   WAY_W        victim way from replacement unit
//  miss_ready    out  1            controller idle, can accept miss
//  arvalid       out  1            read request valid
//  araddr        out  ADDR_W       line-aligned burst address (offset bits zero)
//  arlen         out  8            LINE_WORDS-1
//  arready       in   1            bus accepts request
//  rvalid        in   1            read beat valid
//  rdata         in   32           read beat data
//  rlast         in   1            final beat marker
//  rready        out  1            controller accepts beat
//  crit_valid    out  1            one-cycle pulse: requested word arrived
//  crit_data     out  32           requested word (valid with crit_valid)
//  wr_en         out  1            one-cycle write of tag+line into cache arrays
//  wr_way        out  WAY_W        latched victim way
//  wr_index      out  INDEX_W      set index of refilled line
//  wr_tag        out  TAG_W        tag of refilled line
//  wr_line       out  32*LINE_WORDS line data, word 0 in LSBs
//  refill_done   out  1            pulse coincident with wr_en
//  proto_err     out  1            sticky: rlast not aligned with final beat
// BEHAVIOUR
//  - Single clock clk; reset rst synchronous, active-high.
//  - Reset: state IDLE; all outputs 0 except miss_ready=1; beat counter 0;
//    proto_err cleared. Line buffer contents are not reset. rst mid-burst
//    abandons the burst with no write. The bus is reset in the same cycle.
//  - FSM IDLE -> AR -> RDATA -> WRITE -> IDLE.
//  - IDLE: miss_ready=1. miss_valid=1 latches miss_addr and replace_line,
//    clears beat counter, and moves to AR. Later changes of replace_line or
//    miss_addr are ignored until the next IDLE.
//  - AR: arvalid=1, araddr={tag,index,OFFSET_W'0}, arlen=LINE_WORDS-1, held
//    stable until arready. arvalid&arready -> RDATA next cycle.
//  - RDATA: rready=1. Each rvalid beat stores rdata at buffer[cnt], then cnt++.
//    The beat with cnt==miss_addr[OFFSET_W-1:2] raises crit_valid/crit_data in
//    that same cycle (combinational from rdata). Beat with cnt==LINE_WORDS-1
//    -> WRITE.
//  - Termination is by counter only. rlast on an earlier beat, or missing
//    rlast on the final beat, sets proto_err (sticky until rst). Beats after
//    the counted final beat are not accepted (rready=0 outside RDATA).
//  - WRITE: exactly one cycle with wr_en=refill_done=1 and wr_* stable; then
//    IDLE, so miss_ready=1 on the next cycle. A miss offered during WRITE is
//    not accepted.
//  - Latency, zero-wait bus: miss accept at cycle 0, arvalid cycle 1, first
//    beat cycle >=2, wr_en one cycle after the final beat.
//  - Counter width $clog2(LINE_WORDS); no wrap is exercised since the final
//    beat exits RDATA.
// STRUCTURE
//  - icache_pkg: state enum {IDLE,AR,RDATA,WRITE}; localparams WAY_W,
//    OFFSET_W, TAG_W; function line_align(addr).
//  - Sub-module icache_line_buffer: LINE_WORDS x 32 register array with
//    write-enable and index, flat read of the whole line.
// TESTING
//  1 Reset: rst=1 for 2 cycles -> miss_ready=1, arvalid=rready=wr_en=proto_err=0.
//  2 Basic refill: miss_addr=0x0000_1234, replace_line=2, arready=1, 8 beats
//    0xA0..0xA7 -> araddr=0x0000_1220, arlen=7; crit_valid on beat 5 (0xA5);
//    wr_en once with wr_way=2, wr_index=0x11, wr_line word0=0xA0.
//  3 Backpressure: arready low 5 cycles, rvalid gapped every other cycle ->
//    araddr stable; 8 beats captured in order; single wr_en.
//  4 Victim latch: replace_line toggles 0->3 during the burst after
//    accept at 1 -> wr_way=1.
//  5 Early rlast: rlast on beat 3 -> proto_err=1 and stays 1; refill still
//    completes after beat 8.
//  6 Reset mid-burst: rst after beat 4 -> no wr_en; next miss refills cleanly.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared geometry, FSM state encoding and address helper for the icache refill path.
package icache_pkg;

  localparam int unsigned WAY_NUM    = 4;
  localparam int unsigned LINE_WORDS = 8;
  localparam int unsigned INDEX_W    = 7;
  localparam int unsigned ADDR_W     = 32;

  localparam int unsigned WAY_W    = $clog2(WAY_NUM);
  localparam int unsigned CNT_W    = $clog2(LINE_WORDS);
  localparam int unsigned OFFSET_W = CNT_W + 2;
  localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned LINE_W   = 32 * LINE_WORDS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AR    = 2'd1,
    RDATA = 2'd2,
    WRITE = 2'd3
  } state_e;

  // Clear the byte-in-line offset so the address points at the start of the line.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
  endfunction

endpackage

// File: rtl/icache_line_buffer.sv
// Line-sized staging buffer: one word written per beat, whole line readable flat.
module icache_line_buffer
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [CNT_W-1:0]  idx_i,
  input  logic [31:0]       wdata_i,
  output logic [LINE_W-1:0] line_o
);

  // Data storage only; contents are meaningless until a full burst lands.
  logic [31:0] mem_q [LINE_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_flat
    assign line_o[32*g +: 32] = mem_q[g];
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Miss handler: latches victim way, issues one read burst, buffers the line,
// forwards the critical word and writes tag+line into the victim way.
module icache_refill_ctrl
  import icache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_valid,
  input  logic [ADDR_W-1:0]   miss_addr,
  input  logic [WAY_W-1:0]    replace_line,
  output logic                miss_ready,
  output logic                arvalid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  input  logic                arready,
  input  logic                rvalid,
  input  logic [31:0]         rdata,
  input  logic                rlast,
  output logic                rready,
  output logic                crit_valid,
  output logic [31:0]         crit_data,
  output logic                wr_en,
  output logic [WAY_W-1:0]    wr_way,
  output logic [INDEX_W-1:0]  wr_index,
  output logic [TAG_W-1:0]    wr_tag,
  output logic [LINE_W-1:0]   wr_line,
  output logic                refill_done,
  output logic                proto_err
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);
  localparam logic [7:0]       BURST_LEN = 8'(LINE_WORDS - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WAY_W-1:0]    way_q, way_d;
  logic                perr_q, perr_d;
  logic                buf_we;
  logic [LINE_W-1:0]   buf_line;
  logic [CNT_W-1:0]    crit_word;

  assign crit_word = addr_q[2 +: CNT_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      way_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      way_q   <= way_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    way_d       = way_q;
    perr_d      = perr_q;
    miss_ready  = 1'b0;
    arvalid     = 1'b0;
    arlen       = 8'd0;
    rready      = 1'b0;
    buf_we      = 1'b0;
    crit_valid  = 1'b0;
    crit_data   = 32'd0;
    wr_en       = 1'b0;
    refill_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
          addr_d  = miss_addr;
          way_d   = replace_line;
          cnt_d   = '0;
          state_d = AR;
        end
      end
      AR: begin
        arvalid = 1'b1;
        arlen   = BURST_LEN;
        if (arready) begin
          state_d = RDATA;
        end
      end
      RDATA: begin
        rready = 1'b1;
        if (rvalid) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == crit_word) begin
            crit_valid = 1'b1;
            crit_data  = rdata;
          end
          // The beat counter ends the burst; rlast is only cross-checked.
          if (rlast != (cnt_q == LAST_BEAT)) begin
            perr_d = 1'b1;
          end
          if (cnt_q == LAST_BEAT) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        wr_en       = 1'b1;
        refill_done = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  icache_line_buffer u_line_buffer (
    .clk     (clk),
    .we_i    (buf_we),
    .idx_i   (cnt_q),
    .wdata_i (rdata),
    .line_o  (buf_line)
  );

  assign araddr    = line_align(addr_q);
  assign wr_way    = way_q;
  assign wr_index  = addr_q[OFFSET_W +: INDEX_W];
  assign wr_tag    = addr_q[ADDR_W-1 -: TAG_W];
  // Buffer is not reset, so only expose it while the write is in flight.
  assign wr_line   = wr_en ? buf_line : '0;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed, table-driven bench for icache_refill_ctrl.
module tb_icache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_valid;
  logic [31:0] miss_addr;
  logic [1:0]  replace_line;
  logic        miss_ready;
  logic        arvalid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        rlast;
  logic        rready;
  logic        crit_valid;
  logic [31:0] crit_data;
  logic        wr_en;
  logic [1:0]  wr_way;
  logic [6:0]  wr_index;
  logic [19:0] wr_tag;
  logic [255:0] wr_line;
  logic        refill_done;
  logic        proto_err;

  icache_refill_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .miss_valid   (miss_valid),
    .miss_addr    (miss_addr),
    .replace_line (replace_line),
    .miss_ready   (miss_ready),
    .arvalid      (arvalid),
    .araddr       (araddr),
    .arlen        (arlen),
    .arready      (arready),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .rlast        (rlast),
    .rready       (rready),
    .crit_valid   (crit_valid),
    .crit_data    (crit_data),
    .wr_en        (wr_en),
    .wr_way       (wr_way),
    .wr_index     (wr_index),
    .wr_tag       (wr_tag),
    .wr_line      (wr_line),
    .refill_done  (refill_done),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  way;
    int          ar_delay;
    bit          gap;
    int          rlast_beat;
    bit          toggle_way;
    logic [31:0] dbase;
    logic [31:0] exp_araddr;
    logic [1:0]  exp_way;
    logic [6:0]  exp_index;
    logic [19:0] exp_tag;
    logic [31:0] exp_crit;
    bit          exp_perr;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;
  int crit_cnt = 0;

  always @(negedge clk) begin
    if (wr_en)      wr_cnt++;
    if (crit_valid) crit_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int wr0 = wr_cnt;
    int cr0 = crit_cnt;
    int cw  = int'(v.addr[4:2]);
    @(posedge clk); #1;
    miss_valid   = 1'b1;
    miss_addr    = v.addr;
    replace_line = v.way;
    @(posedge clk); #1;
    miss_valid = 1'b0;
    miss_addr  = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("arvalid", arvalid, 1'b1);
    chk("araddr", araddr, v.exp_araddr);
    chk("arlen", arlen, 8'd7);
    for (int d = 0; d < v.ar_delay; d++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("araddr_hold", {arvalid, araddr}, {1'b1, v.exp_araddr});
    end
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (v.gap && b > 0) begin
        rvalid = 1'b0;
        @(posedge clk); #1;
      end
      rvalid = 1'b1;
      rdata  = v.dbase + 32'(b);
      rlast  = (b == v.rlast_beat);
      if (v.toggle_way) replace_line = b[0] ? 2'd3 : 2'd0;
      @(negedge clk);
      if (b == 0) chk("rready", rready, 1'b1);
      if (b == cw) begin
        chk("crit_valid", crit_valid, 1'b1);
        chk("crit_data", crit_data, v.exp_crit);
      end
      @(posedge clk); #1;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    @(negedge clk);
    chk("wr_en", wr_en, 1'b1);
    chk("refill_done", refill_done, 1'b1);
    chk("wr_way", wr_way, v.exp_way);
    chk("wr_index", wr_index, v.exp_index);
    chk("wr_tag", wr_tag, v.exp_tag);
    for (int w = 0; w < 8; w++) begin
      logic [255:0] ln;
      ln = wr_line;
      chk("wr_line_word", ln[32*w +: 32], v.dbase + 32'(w));
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("miss_ready_after", miss_ready, 1'b1);
    chk("wr_en_after", wr_en, 1'b0);
    chk("proto_err", proto_err, v.exp_perr);
    chk("wr_pulses", 64'(wr_cnt - wr0), 64'd1);
    chk("crit_pulses", 64'(crit_cnt - cr0), 64'd1);
  endtask

  vec_t tbl[4];
  vec_t v;
  int   wr_snap;

  initial begin
    rst = 1'b1; miss_valid = 1'b0; miss_addr = '0; replace_line = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rlast = 1'b0;

    // addr, way, ar_delay, gap, rlast_beat, toggle, dbase, araddr, way, index, tag, crit, perr
    tbl[0] = '{32'h0000_1234, 2'd2, 0, 1'b0, 7, 1'b0, 32'hA0,
               32'h0000_1220, 2'd2, 7'h11, 20'h00001, 32'hA5, 1'b0};
    tbl[1] = '{32'hDEAD_BEEF, 2'd1, 5, 1'b1, 7, 1'b0, 32'h100,
               32'hDEAD_BEE0, 2'd1, 7'h77, 20'hDEADB, 32'h103, 1'b0};
    tbl[2] = '{32'h8000_0FE0, 2'd3, 1, 1'b0, 7, 1'b0, 32'h200,
               32'h8000_0FE0, 2'd3, 7'h7F, 20'h80000, 32'h200, 1'b0};
    tbl[3] = '{32'h0000_003C, 2'd0, 0, 1'b1, 7, 1'b0, 32'h300,
               32'h0000_0020, 2'd0, 7'h01, 20'h00000, 32'h307, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_miss_ready", miss_ready, 1'b1);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_proto_err", proto_err, 1'b0);
    chk("rst_araddr", araddr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(tbl[i]);

    // Victim way must stay as latched at accept despite replace_line churn.
    v = '{32'h0000_2468, 2'd1, 0, 1'b0, 7, 1'b1, 32'h500,
          32'h0000_2460, 2'd1, 7'h23, 20'h00002, 32'h502, 1'b0};
    run_vec(v);

    // Early rlast flags proto_err but the refill still completes; then sticky.
    v = '{32'h0000_1234, 2'd2, 0, 1'b0, 3, 1'b0, 32'h600,
          32'h0000_1220, 2'd2, 7'h11, 20'h00001, 32'h605, 1'b1};
    run_vec(v);
    v = tbl[0];
    v.exp_perr = 1'b1;
    run_vec(v);

    // Reset mid-burst: no write, proto_err cleared, then a clean refill.
    wr_snap = wr_cnt;
    @(posedge clk); #1;
    miss_valid = 1'b1; miss_addr = 32'h5000_0040; replace_line = 2'd2;
    @(posedge clk); #1;
    miss_valid = 1'b0; arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      rvalid = 1'b1; rdata = 32'hDEAD_0000 + 32'(b);
      @(posedge clk); #1;
    end
    rvalid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_miss_ready", miss_ready, 1'b1);
    chk("midrst_rready", rready, 1'b0);
    chk("midrst_proto_err", proto_err, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_no_write", 64'(wr_cnt - wr_snap), 64'd0);

    v = '{32'h5000_0040, 2'd2, 0, 1'b0, 7, 1'b0, 32'h400,
          32'h5000_0040, 2'd2, 7'h02, 20'h50000, 32'h400, 1'b0};
    run_vec(v);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
